// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit: MULT/MULTU/DIV/DIVU over 32 cycles plus MTHI/MTLO.
// Owns the architectural HI/LO registers; busy stalls the decoder.
module muldiv_sequencer #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   araw;
    logic               isdiv;
    logic               negq;
    logic               negr;
    logic               div0;

    logic               arith;
    logic               mthi;
    logic               mtlo;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign arith = ~op[2];
    assign mthi  = (op == 3'b100);
    assign mtlo  = (op == 3'b101);
    assign sgn   = ~op[0];
    assign abs_a = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add step: multiplier sits in the low half and drains out the bottom.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nx;

    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, ma} : {(WIDTH+1){1'b0}});
    assign mul_nx = {msum, acc[WIDTH-1:1]};

    // Restoring step: rem < divisor keeps the trial difference within WIDTH+1 bits.
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign rsh    = {rem, acc[WIDTH-1]};
    assign diff   = rsh - {1'b0, mb};
    assign ge     = ~diff[WIDTH];
    assign rem_nx = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
    assign quo_nx = {acc[WIDTH-2:0], ge};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;

    assign prod = negq ? (~acc + 1'b1) : acc;
    assign quo  = negq ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign rmd  = negr ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            rem   <= '0;
            ma    <= '0;
            mb    <= '0;
            araw  <= '0;
            isdiv <= 1'b0;
            negq  <= 1'b0;
            negr  <= 1'b0;
            div0  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            unique case (1'b1)
                                arith: begin
                                    ma    <= abs_a;
                                    mb    <= abs_b;
                                    araw  <= a;
                                    isdiv <= op[1];
                                    negq  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    negr  <= sgn & a[WIDTH-1];
                                    div0  <= (b == '0);
                                    acc   <= {{WIDTH{1'b0}},
                                              op[1] ? abs_a : abs_b};
                                    rem   <= '0;
                                    cnt   <= '0;
                                    busy  <= 1'b1;
                                    state <= RUN;
                                end
                                mthi: hi <= a;
                                mtlo: lo <= a;
                                default: ;
                            endcase
                        end
                    end
                    RUN: begin
                        cnt <= cnt + 1'b1;
                        if (isdiv) begin
                            rem <= rem_nx;
                            acc <= {acc[2*WIDTH-1:WIDTH], quo_nx};
                        end else begin
                            acc <= mul_nx;
                        end
                        if (cnt == CW'(WIDTH - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        if (!isdiv) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end else if (div0) begin
                            hi <= araw;
                            lo <= DIV0_LO;
                        end else begin
                            hi <= rmd;
                            lo <= quo;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency,
// MTHI/MTLO, abort and asynchronous reset behaviour.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    muldiv_sequencer #(.WIDTH(32), .DIV0_LO(32'hFFFFFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int bc;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n  = 0;
        bc = 1;
        while (!done && n < 100) begin
            tick();
            n++;
            if (busy) bc++;
        end
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " busycnt"}, 32'(bc), 32'd33);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        run("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
        chk("done pulse", 32'(done), 32'd1);
        run("mult", 3'd0, 32'hFFFFFFFD, 32'd5,
            32'hFFFFFFFF, 32'hFFFFFFF1);
        run("div", 3'd2, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run("divu0", 3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
        run("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
            32'd0, 32'h80000000);
        tick();
        chk("done once", 32'(done), 32'd0);

        start = 1'b1; op = 3'd5; a = 32'h1111;
        tick();
        chk("mtlo lo", lo, 32'h1111);
        chk("mtlo busy", 32'(busy), 32'd0);
        op = 3'd4; a = 32'hAAAA;
        tick();
        start = 1'b0;
        chk("mthi hi", hi, 32'hAAAA);
        chk("mthi done", 32'(done), 32'd0);

        start = 1'b1; op = 3'd6; a = 32'h7777;
        tick();
        start = 1'b0;
        chk("rsvd busy", 32'(busy), 32'd0);
        chk("rsvd hi", hi, 32'hAAAA);

        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        tick();
        op = 3'd5; a = 32'h5555;
        chk("ab busy", 32'(busy), 32'd1);
        repeat (9) tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab busy0", 32'(busy), 32'd0);
        chk("ab done", 32'(done), 32'd0);
        chk("ab hi", hi, 32'hAAAA);
        chk("ab lo", lo, 32'h1111);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen++;
        end
        chk("ab nodone", 32'(seen), 32'd0);

        start = 1'b1; abort = 1'b1; op = 3'd5; a = 32'h2222;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abidle lo", lo, 32'h1111);
        chk("abidle busy", 32'(busy), 32'd0);

        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (32) tick();
        chk("fix busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abfix done", 32'(done), 32'd0);
        chk("abfix busy", 32'(busy), 32'd0);
        chk("abfix hi", hi, 32'hAAAA);
        chk("abfix lo", lo, 32'h1111);

        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        repeat (20) tick();
        #2 reset = 1'b1;
        #1;
        chk("mrst hi", hi, 32'd0);
        chk("mrst lo", lo, 32'd0);
        chk("mrst busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run("divu2", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run("b2b", 3'd0, 32'hFFFFFFFD, 32'd5,
            32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
